// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter and its round-robin picker.
// The packed FIFO word is {last, id, data}, data at the LSBs.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // A single requester still needs a one-bit ID field.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DATA_LSB = 0;

  function automatic int id_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int last_bit(input int data_w, input int id_w);
    return data_w + id_w;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Produces both a one-hot grant and its encoded index.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          found
);

  int c;

  // Walk offsets from ptr; the inner loop keeps every select index constant.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      for (int j = 0; j < N; j++) begin
        if (!found && (j == c) && req[j]) begin
          gnt[j] = 1'b1;
          idx    = IW'(j);
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async_fifo write port between NUM_REQ sources.
// Bursts end on a packet's last beat or after MAX_BURST beats; beats are tagged {last, id, data}.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int MAX_BURST  = 8,
  parameter int ID_WIDTH   = id_width(NUM_REQ),
  parameter int FIFO_WIDTH = DATA_WIDTH + ID_WIDTH + 1
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst_n,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_rdy,
  input  logic                          fifo_full,
  input  logic                          fifo_afull,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_wr_data,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e            state_q, state_d;
  logic [ID_WIDTH-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0]    owner_oh_q, owner_oh_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0]    pick_gnt;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  pick_found;

  logic                  own_vld, own_last;
  logic [DATA_WIDTH-1:0] own_data;
  logic                  beat_acc, burst_end;
  logic [CNT_W-1:0]      cnt_inc;
  logic [ID_WIDTH-1:0]   ptr_next;

  rr_pick #(.N(NUM_REQ), .IW(ID_WIDTH)) u_pick (
    .req   (req_vld),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Owner is kept one-hot as well so the source mux needs no variable index.
  always_comb begin
    own_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_oh_q[i]) own_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign own_vld   = |(req_vld  & owner_oh_q);
  assign own_last  = |(req_last & owner_oh_q);

  assign busy      = (state_q == BURST);
  assign grant_id  = owner_q;
  assign beat_acc  = busy & own_vld & ~fifo_full;
  assign cnt_inc   = beat_cnt_q + 1'b1;
  assign burst_end = beat_acc & (own_last | (cnt_inc == CNT_W'(MAX_BURST)));
  assign ptr_next  = (owner_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  // full gates the write port combinationally; afull only blocks new grants.
  assign req_rdy      = (busy & ~fifo_full) ? owner_oh_q : '0;
  assign fifo_wr_en   = beat_acc;
  assign fifo_wr_data = {own_last, owner_q, own_data};

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    owner_oh_d = owner_oh_q;
    beat_cnt_d = beat_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found && !fifo_afull) begin
          state_d    = BURST;
          owner_d    = pick_idx;
          owner_oh_d = pick_gnt;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        if (beat_acc) begin
          beat_cnt_d = cnt_inc;
          if (burst_end) begin
            state_d  = IDLE;
            rr_ptr_d = ptr_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      owner_oh_q <= '0;
      beat_cnt_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      owner_oh_q <= owner_oh_d;
      beat_cnt_q <= beat_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

endmodule
